// File: rtl/ece453.sv
// ece453: memory-mapped GPIO block with a DMX512 transmitter.
// A 513-byte universe buffer is loaded from DMX_DATA/DMX_ADDR/DMX_SIZE
// when a transmission starts, then sent as break, mark-after-break and 513 frames.
// Optional interrupt support is enabled by defining ECE453_IRQ_EN.
module ece453 #(
  parameter int CLK_HZ  = 50000000,
  parameter int BIT_CYC = CLK_HZ / 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [31:0] slave_readdata,
  input  logic [3:0]  slave_byteenable,
  input  logic [31:0] gpio_inputs,
  output logic [31:0] gpio_outputs,
  output logic        irq_out
);

  localparam logic [31:0] BIT_LEN = 32'(BIT_CYC);
  localparam logic [31:0] BRK_LEN = 32'(25 * BIT_CYC);
  localparam logic [31:0] MAB_LEN = 32'(3 * BIT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_COMMIT, S_BREAK, S_MAB, S_SLOTS, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  slot_q, slot_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic [31:0] dmx_data_q, dmx_data_d;
  logic [9:0]  dmx_addr_q, dmx_addr_d;
  logic [31:0] dmx_size_q, dmx_size_d;
  logic [29:0] gpio_out_q, gpio_out_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] gin_s1_q, gin_s2_q;
  logic        im_q, im_d;
  logic [7:0]  dmx_buf_q [0:512];

  logic        busy;
  logic        buf_we;
  logic [9:0]  buf_wa;
  logic [7:0]  buf_wd;
  logic [2:0]  n_bytes;
  logic [9:0]  room;
  logic        unused_be;

  // Byte enables carry no meaning here: every write is full width.
  assign unused_be = ^slave_byteenable;

  // Line level of frame bit idx: start bit, 8 data bits LSB first, 2 stop bits.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic [3:0] j;
    j = idx - 4'd1;
    if (idx == 4'd0)      return 1'b0;
    else if (idx <= 4'd8) return b[j[2:0]];
    else                  return 1'b1;
  endfunction

  assign busy         = (state_q != S_IDLE);
  assign gpio_outputs = {gpio_out_q, busy, tx_q};
  assign slave_readdata = rdata_q;

`ifdef ECE453_IRQ_EN
  assign irq_out = im_q & done_q;
`else
  assign irq_out = 1'b0;
`endif

  // Number of bytes committed: min(size, 4, room left in the universe).
  always_comb begin
    room    = 10'd0;
    n_bytes = 3'd0;
    if (dmx_addr_q < 10'd513 && dmx_size_q != 32'd0) begin
      room    = 10'd513 - dmx_addr_q;
      n_bytes = (dmx_size_q < 32'd4) ? dmx_size_q[2:0] : 3'd4;
      if (room < {7'd0, n_bytes}) n_bytes = room[2:0];
    end
  end

  // Next-state logic for the transmitter, register file and read port.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    slot_d     = slot_q;
    tx_d       = tx_q;
    done_d     = done_q;
    dmx_data_d = dmx_data_q;
    dmx_addr_d = dmx_addr_q;
    dmx_size_d = dmx_size_q;
    gpio_out_d = gpio_out_q;
    im_d       = im_q;
    rdata_d    = rdata_q;
    buf_we     = 1'b0;
    buf_wa     = dmx_addr_q + {7'd0, k_q};
    buf_wd     = dmx_data_q[{k_q[1:0], 3'b000} +: 8];

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (slave_write && slave_address == 4'd0 && slave_writedata[0]) begin
          state_d = S_COMMIT;
          k_d     = 3'd0;
        end
      end
      S_COMMIT: begin
        if (k_q < n_bytes) buf_we = 1'b1;
        if (({1'b0, k_q} + 4'd1) >= {1'b0, n_bytes}) begin
          state_d = S_BREAK;
          cnt_d   = 32'd0;
          tx_d    = 1'b0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_BREAK: begin
        if (cnt_q == BRK_LEN - 32'd1) begin
          state_d = S_MAB;
          cnt_d   = 32'd0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_MAB: begin
        if (cnt_q == MAB_LEN - 32'd1) begin
          state_d = S_SLOTS;
          cnt_d   = 32'd0;
          bit_d   = 4'd0;
          slot_d  = 10'd0;
          tx_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SLOTS: begin
        if (cnt_q == BIT_LEN - 32'd1) begin
          cnt_d = 32'd0;
          if (bit_q == 4'd10) begin
            if (slot_q == 10'd512) begin
              state_d = S_DONE;
              tx_d    = 1'b1;
            end else begin
              slot_d = slot_q + 10'd1;
              bit_d  = 4'd0;
              tx_d   = 1'b0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = frame_bit(dmx_buf_q[slot_q], bit_q + 4'd1);
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        slot_d  = 10'd0;
        tx_d    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (slave_write) begin
      case (slave_address)
        4'd1: if (slave_writedata[1]) done_d = 1'b0;
        4'd2: im_d       = slave_writedata[0];
        4'd3: gpio_out_d = slave_writedata[31:2];
        4'd4: dmx_data_d = slave_writedata;
        4'd5: dmx_addr_d = slave_writedata[9:0];
        4'd6: dmx_size_d = slave_writedata;
        default: ;
      endcase
    end
    // A completing frame outranks a simultaneous clear.
    if (state_q == S_DONE) done_d = 1'b1;

    if (slave_read) begin
      case (slave_address)
        4'd1: rdata_d = {19'd0, slot_q, 1'b0, done_q, busy};
`ifdef ECE453_IRQ_EN
        4'd2: rdata_d = {31'd0, im_q};
`endif
        4'd3: rdata_d = {gpio_out_q, 2'b00};
        4'd4: rdata_d = dmx_data_q;
        4'd5: rdata_d = {22'd0, dmx_addr_q};
        4'd6: rdata_d = dmx_size_q;
        4'd7: rdata_d = gin_s2_q;
        default: rdata_d = 32'd0;
      endcase
    end
  end

  // State, registers, input synchroniser and universe buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      k_q        <= 3'd0;
      cnt_q      <= 32'd0;
      bit_q      <= 4'd0;
      slot_q     <= 10'd0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      dmx_data_q <= 32'd0;
      dmx_addr_q <= 10'd0;
      dmx_size_q <= 32'd0;
      gpio_out_q <= 30'd0;
      im_q       <= 1'b0;
      rdata_q    <= 32'd0;
      gin_s1_q   <= 32'd0;
      gin_s2_q   <= 32'd0;
      for (int i = 0; i < 513; i++) dmx_buf_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      slot_q     <= slot_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      dmx_data_q <= dmx_data_d;
      dmx_addr_q <= dmx_addr_d;
      dmx_size_q <= dmx_size_d;
      gpio_out_q <= gpio_out_d;
`ifdef ECE453_IRQ_EN
      im_q       <= im_d;
`else
      im_q       <= 1'b0;
`endif
      rdata_q    <= rdata_d;
      gin_s1_q   <= gpio_inputs;
      gin_s2_q   <= gin_s1_q;
      if (buf_we) dmx_buf_q[buf_wa] <= buf_wd;
    end
  end

endmodule

// File: tb/tb_ece453.sv
// Directed bench for ece453: register access, three DMX frames decoded
// from the tx line against a hand-maintained universe image, and reset abort.
module tb_ece453;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  slave_address = 4'd0;
  logic        slave_read = 1'b0;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = 32'd0;
  logic [31:0] slave_readdata;
  logic [3:0]  slave_byteenable = 4'hF;
  logic [31:0] gpio_inputs = 32'd0;
  logic [31:0] gpio_outputs;
  logic        irq_out;

  ece453 #(.CLK_HZ(500000), .BIT_CYC(B)) dut (
    .clk(clk), .reset(reset), .slave_address(slave_address),
    .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
    .slave_byteenable(slave_byteenable), .gpio_inputs(gpio_inputs),
    .gpio_outputs(gpio_outputs), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

`ifdef ECE453_IRQ_EN
  localparam logic [31:0] IRQ_ON = 32'd1;
`else
  localparam logic [31:0] IRQ_ON = 32'd0;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0]  exp_buf [0:512];
  logic [7:0]  cap [0:512];
  int brk_len, mab_len, fr_err;
  logic [31:0] rv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Bus tasks are entered at a falling edge and return at a falling edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    slave_address = a; slave_read = 1'b1;
    @(negedge clk);
    slave_read = 1'b0;
    d = slave_readdata;
  endtask

  // Decode one complete DMX transmission from gpio_outputs[0].
  task automatic capture();
    int n;
    logic [7:0] v;
    brk_len = 0; mab_len = 0; fr_err = 0; n = 0;
    while (gpio_outputs[0] !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    check("break_start_seen", 32'(n < 200), 32'd1);
    if (n >= 200) return;
    while (gpio_outputs[0] === 1'b0 && brk_len < 1000) begin brk_len++; @(negedge clk); end
    while (gpio_outputs[0] === 1'b1 && mab_len < 1000) begin mab_len++; @(negedge clk); end
    for (int s = 0; s < 513; s++) begin
      v = 8'h00;
      for (int i = 0; i < 11; i++) begin
        if (i == 0 && gpio_outputs[0] !== 1'b0) fr_err++;
        if (i >= 9 && gpio_outputs[0] !== 1'b1) fr_err++;
        if (i >= 1 && i <= 8) v[i-1] = gpio_outputs[0];
        repeat (B) @(negedge clk);
      end
      cap[s] = v;
    end
    n = 0;
    while (gpio_outputs[1] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("frame_end_seen", 32'(n < 100), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    int nb;
    nb = 0;
    for (int s = 0; s < 513; s++) if (cap[s] !== exp_buf[s]) nb++;
    check({tag, "_slots_wrong"}, 32'(nb), 32'd0);
    check({tag, "_framing_errs"}, 32'(fr_err), 32'd0);
    check({tag, "_break_len"}, 32'(brk_len), 32'(25 * B));
    check({tag, "_mab_len"}, 32'(mab_len), 32'(3 * B));
  endtask

  initial begin
    for (int s = 0; s < 513; s++) exp_buf[s] = 8'h00;
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("rst_irq", 32'(irq_out), 32'd0);
    check("rst_rdata", slave_readdata, 32'd0);
    check("rst_gpio_out", gpio_outputs, 32'h1);
    reset = 1'b0;
    @(negedge clk);

    rd(4'd1, rv); check("status_after_reset", rv, 32'd0);
    check("gpio_after_reset", gpio_outputs, 32'h1);

    // Register storage widths and unmapped space.
    wr(4'd5, 32'hFFFF_FFFF); rd(4'd5, rv); check("dmx_addr_width", rv, 32'h3FF);
    wr(4'd3, 32'hFFFF_FFFF); rd(4'd3, rv); check("gpio_out_rb", rv, 32'hFFFF_FFFC);
    check("gpio_out_pins", gpio_outputs, 32'hFFFF_FFFD);
    wr(4'd3, 32'd0);
    wr(4'd9, 32'h1234); rd(4'd9, rv); check("unmapped_rd", rv, 32'd0);
    rd(4'd0, rv); check("control_rd", rv, 32'd0);
    gpio_inputs = 32'hA5A5_5A5A;
    repeat (3) @(negedge clk);
    rd(4'd7, rv); check("gpio_in", rv, 32'hA5A5_5A5A);
    wr(4'd2, 32'd1); rd(4'd2, rv); check("im_rb", rv, IRQ_ON);

    // Commit clipped by the end of the universe.
    wr(4'd4, 32'hFFFF_FFFF); wr(4'd5, 32'h1FE); wr(4'd6, 32'h0022_2222);
    wr(4'd0, 32'h1);
    rd(4'd1, rv); check("busy_after_start", rv & 32'h1, 32'h1);
    exp_buf[510] = 8'hFF; exp_buf[511] = 8'hFF; exp_buf[512] = 8'hFF;
    capture();
    check_frame("edge");
    rd(4'd1, rv); check("status_done", rv, 32'h2);
    check("irq_on_done", 32'(irq_out), IRQ_ON);
    wr(4'd1, 32'h2);
    check("irq_cleared", 32'(irq_out), 32'd0);
    rd(4'd1, rv); check("status_cleared", rv, 32'd0);

    // Two-byte commit at slot 1; slot 3 keeps its old value.
    wr(4'd4, 32'h4433_2211); wr(4'd5, 32'd1); wr(4'd6, 32'd2);
    wr(4'd0, 32'h1);
    exp_buf[1] = 8'h11; exp_buf[2] = 8'h22;
    capture();
    check_frame("two");
    wr(4'd1, 32'h2);

    // Size above four is limited to four; a restart while busy is ignored.
    wr(4'd4, 32'h0DCC_BBAA); wr(4'd5, 32'd3); wr(4'd6, 32'h10);
    wr(4'd0, 32'h1);
    exp_buf[3] = 8'hAA; exp_buf[4] = 8'hBB; exp_buf[5] = 8'hCC; exp_buf[6] = 8'h0D;
    fork
      capture();
      begin
        repeat (200) @(negedge clk);
        wr(4'd4, 32'h5555_5555); wr(4'd5, 32'd20); wr(4'd0, 32'h1);
      end
    join
    check_frame("busy");
    repeat (100) @(negedge clk);
    check("no_second_frame", gpio_outputs & 32'h3, 32'h1);
    rd(4'd1, rv); check("status_after_busy", rv, 32'h2);
    wr(4'd1, 32'h2);

    // Reset in the middle of the slot phase.
    wr(4'd0, 32'h1);
    repeat (2000) @(negedge clk);
    rd(4'd1, rv); check("busy_mid_slots", rv & 32'h1, 32'h1);
    #2 reset = 1'b1;
    #1 check("abort_gpio", gpio_outputs, 32'h1);
    check("abort_irq", 32'(irq_out), 32'd0);
    @(negedge clk);
    rd(4'd1, rv); check("abort_rdata_in_reset", rv, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    rd(4'd1, rv); check("abort_status", rv, 32'd0);
    check("abort_gpio_after", gpio_outputs, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
